// File: rtl/analog_input_conditioner_if.sv
// Signal bundle between the framework input side and analog_input_conditioner.
// master drives controls and samples positions; slave is the conditioner itself.
interface analog_input_conditioner_if #(
  parameter int NUM_CH = 2,
  parameter int POS_W  = 8
);
  logic                    ce_sample;
  logic [2*NUM_CH-1:0]     cfg_mode;
  logic [NUM_CH-1:0]       cfg_invert;
  logic [8*NUM_CH-1:0]     joy_analog;
  logic [8*NUM_CH-1:0]     paddle;
  logic [9*NUM_CH-1:0]     spinner;
  logic [2*NUM_CH-1:0]     joy_dig;
  logic [POS_W*NUM_CH-1:0] pos_out;
  logic [NUM_CH-1:0]       pos_valid;
  logic [NUM_CH-1:0]       moved;

  modport master (
    output ce_sample, cfg_mode, cfg_invert, joy_analog, paddle, spinner, joy_dig,
    input  pos_out, pos_valid, moved
  );

  modport slave (
    input  ce_sample, cfg_mode, cfg_invert, joy_analog, paddle, spinner, joy_dig,
    output pos_out, pos_valid, moved
  );
endinterface

// File: rtl/analog_input_conditioner.sv
// Per-channel joystick/paddle/spinner/digital to absolute position conditioner.
// Optional macro ANALOG_DEADZONE_EN zeroes small joystick deflections.
module analog_input_conditioner #(
  parameter int NUM_CH     = 2,
  parameter int POS_W      = 8,
  parameter int SPIN_SHIFT = 0,
  parameter int DIG_STEP   = 4,
  parameter int DEADZONE   = 8
) (
  input logic                  clk_sys,
  input logic                  reset,
  analog_input_conditioner_if.slave bus
);

  // Wide enough for acc plus a shifted 8-bit delta with sign and overflow headroom.
  localparam int MAG_W = (POS_W > 8 + SPIN_SHIFT) ? POS_W : 8 + SPIN_SHIFT;
  localparam int SUM_W = MAG_W + 2;

  localparam logic [POS_W-1:0]        CENTER  = {1'b1, {(POS_W-1){1'b0}}};
  localparam logic signed [SUM_W-1:0] MAX_POS = {{(SUM_W-POS_W){1'b0}}, {POS_W{1'b1}}};
  localparam logic signed [SUM_W-1:0] STEP    = SUM_W'(DIG_STEP);

  typedef enum logic [1:0] {
    MODE_JOY  = 2'b00,
    MODE_PAD  = 2'b01,
    MODE_SPIN = 2'b10,
    MODE_DIG  = 2'b11
  } mode_t;

  if (NUM_CH < 1 || NUM_CH > 4 || POS_W < 8 || POS_W > 16 ||
      SPIN_SHIFT < 0 || SPIN_SHIFT > 4 || DIG_STEP < 0 || DEADZONE < 0) begin : g_bad_param
    $error("analog_input_conditioner: parameter out of range");
  end

  logic [POS_W-1:0] acc      [NUM_CH];
  logic [POS_W-1:0] acc_next [NUM_CH];
  logic [POS_W-1:0] pos_q    [NUM_CH];
  logic [POS_W-1:0] pos_new  [NUM_CH];
  mode_t            mode_prev[NUM_CH];
  logic [NUM_CH-1:0] tog_prev;
  logic [NUM_CH-1:0] valid_q;
  logic [NUM_CH-1:0] moved_q;

  function automatic logic [POS_W-1:0] saturate(input logic signed [SUM_W-1:0] v);
    if (v < 0)
      return '0;
    else if (v > MAX_POS)
      return '1;
    else
      return v[POS_W-1:0];
  endfunction

  function automatic logic [POS_W-1:0] joy_to_pos(input logic [7:0] x);
    logic [7:0] xv;
    xv = x;
`ifdef ANALOG_DEADZONE_EN
    begin
      int xi;
      xi = int'($signed(x));
      if (xi > -DEADZONE && xi < DEADZONE)
        xv = 8'h00;
    end
`endif
    // Offset-binary: -128 maps to the bottom of the range, 0 to CENTER.
    return POS_W'(xv ^ 8'h80) << (POS_W - 8);
  endfunction

  function automatic logic [POS_W-1:0] channel_next(
    input mode_t            mode,
    input mode_t            prev_mode,
    input logic             ce,
    input logic [POS_W-1:0] acc_cur,
    input logic [7:0]       joy,
    input logic [7:0]       pad,
    input logic [8:0]       spin,
    input logic             tog_last,
    input logic [1:0]       dig
  );
    logic signed [SUM_W-1:0] acc_ext;
    logic signed [SUM_W-1:0] delta;
    logic [POS_W-1:0]        result;
    acc_ext = $signed({{(SUM_W-POS_W){1'b0}}, acc_cur});
    delta   = SUM_W'($signed(spin[7:0])) <<< SPIN_SHIFT;
    result  = acc_cur;
    if (mode != prev_mode) begin
      result = CENTER;
    end else begin
      case (mode)
        MODE_JOY:  if (ce) result = joy_to_pos(joy);
        MODE_PAD:  if (ce) result = POS_W'(pad) << (POS_W - 8);
        MODE_SPIN: if (spin[8] != tog_last) result = saturate(acc_ext + delta);
        MODE_DIG: begin
          if (ce && dig == 2'b10)
            result = saturate(acc_ext + STEP);
          else if (ce && dig == 2'b01)
            result = saturate(acc_ext - STEP);
        end
        default: result = acc_cur;
      endcase
    end
    return result;
  endfunction

  // Next accumulator and candidate output for every channel.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      acc_next[c] = channel_next(mode_t'(bus.cfg_mode[2*c +: 2]), mode_prev[c],
                                 bus.ce_sample, acc[c],
                                 bus.joy_analog[8*c +: 8], bus.paddle[8*c +: 8],
                                 bus.spinner[9*c +: 9], tog_prev[c],
                                 bus.joy_dig[2*c +: 2]);
      pos_new[c]  = bus.cfg_invert[c] ? ~acc[c] : acc[c];
    end
  end

  // Output loads the accumulator value held before this cycle's update.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        acc[c]       <= CENTER;
        pos_q[c]     <= CENTER;
        mode_prev[c] <= mode_t'(bus.cfg_mode[2*c +: 2]);
        tog_prev[c]  <= bus.spinner[9*c + 8];
        valid_q[c]   <= 1'b0;
        moved_q[c]   <= 1'b0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        acc[c]       <= acc_next[c];
        mode_prev[c] <= mode_t'(bus.cfg_mode[2*c +: 2]);
        tog_prev[c]  <= bus.spinner[9*c + 8];
        valid_q[c]   <= bus.ce_sample;
        moved_q[c]   <= bus.ce_sample && (pos_new[c] != pos_q[c]);
        if (bus.ce_sample)
          pos_q[c] <= pos_new[c];
      end
    end
  end

  always_comb begin
    bus.pos_out = '0;
    for (int c = 0; c < NUM_CH; c++)
      bus.pos_out[POS_W*c +: POS_W] = pos_q[c];
  end

  assign bus.pos_valid = valid_q;
  assign bus.moved     = moved_q;

endmodule

// File: tb/tb_analog_input_conditioner.sv
// Directed self-checking bench for analog_input_conditioner (NUM_CH=2, POS_W=8).
// Expected joystick dead-zone result follows ANALOG_DEADZONE_EN.
module tb_analog_input_conditioner;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk_sys = ~clk_sys;

  analog_input_conditioner_if #(.NUM_CH(2), .POS_W(8)) bus ();

  analog_input_conditioner #(
    .NUM_CH(2), .POS_W(8), .SPIN_SHIFT(0), .DIG_STEP(4), .DEADZONE(8)
  ) dut (
    .clk_sys(clk_sys),
    .reset  (reset),
    .bus    (bus)
  );

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic pulse_ce();
    bus.ce_sample = 1'b1;
    tick();
    bus.ce_sample = 1'b0;
  endtask

  task automatic flip_spin(input int ch, input logic [7:0] d);
    bus.spinner[9*ch + 8]  = ~bus.spinner[9*ch + 8];
    bus.spinner[9*ch +: 8] = d;
  endtask

  task automatic check_pos(input string name, input int ch, input logic [7:0] exp_pos,
                           input logic exp_valid, input logic exp_moved);
    logic [7:0] p;
    p = bus.pos_out[8*ch +: 8];
    checks++;
    if (p !== exp_pos || bus.pos_valid[ch] !== exp_valid || bus.moved[ch] !== exp_moved) begin
      failures++;
      $display("[TB] FAIL %s ch%0d: pos=%02h valid=%b moved=%b, required pos=%02h valid=%b moved=%b",
               name, ch, p, bus.pos_valid[ch], bus.moved[ch], exp_pos, exp_valid, exp_moved);
    end
  endtask

  task automatic test_reset();
    bus.ce_sample  = 1'b0;
    bus.cfg_mode   = 4'b1010;
    bus.cfg_invert = 2'b00;
    bus.joy_analog = '0;
    bus.paddle     = '0;
    bus.spinner    = '0;
    bus.joy_dig    = '0;
    reset = 1'b1;
    tick();
    flip_spin(0, 8'd5);
    flip_spin(1, 8'd5);
    tick();
    reset = 1'b0;
    tick();
    tick();
    check_pos("reset", 0, 8'h80, 1'b0, 1'b0);
    check_pos("reset", 1, 8'h80, 1'b0, 1'b0);
    pulse_ce();
    pulse_ce();
    check_pos("reset_no_event", 0, 8'h80, 1'b1, 1'b0);
    check_pos("reset_no_event", 1, 8'h80, 1'b1, 1'b0);
  endtask

  task automatic test_joystick();
    bus.cfg_mode[1:0]   = 2'b00;
    bus.joy_analog[7:0] = 8'h40;
    tick();
    pulse_ce();
    check_pos("joy_first", 0, 8'h80, 1'b1, 1'b0);
    pulse_ce();
    check_pos("joy_c0", 0, 8'hC0, 1'b1, 1'b1);
    tick();
    check_pos("joy_pulse_end", 0, 8'hC0, 1'b0, 1'b0);
    bus.cfg_invert[0] = 1'b1;
    pulse_ce();
    check_pos("joy_invert", 0, 8'h3F, 1'b1, 1'b1);
    bus.cfg_invert[0] = 1'b0;
  endtask

  task automatic test_paddle();
    bus.cfg_mode[1:0] = 2'b01;
    bus.paddle[7:0]   = 8'h37;
    tick();
    pulse_ce();
    pulse_ce();
    check_pos("paddle", 0, 8'h37, 1'b1, 1'b1);
  endtask

  task automatic test_spinner_saturation();
    for (int i = 0; i < 3; i++) begin
      flip_spin(1, 8'd5);
      tick();
    end
    pulse_ce();
    check_pos("spin_plus5", 1, 8'h8F, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      flip_spin(1, 8'd127);
      tick();
    end
    pulse_ce();
    check_pos("spin_sat_high", 1, 8'hFF, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      flip_spin(1, 8'h80);
      tick();
    end
    pulse_ce();
    check_pos("spin_sat_low", 1, 8'h00, 1'b1, 1'b1);
  endtask

  task automatic test_digital();
    bus.cfg_mode[1:0] = 2'b11;
    bus.joy_dig[1:0]  = 2'b10;
    tick();
    pulse_ce();
    pulse_ce();
    pulse_ce();
    check_pos("dig_right_lag", 0, 8'h88, 1'b1, 1'b1);
    bus.joy_dig[1:0] = 2'b00;
    pulse_ce();
    check_pos("dig_right_8c", 0, 8'h8C, 1'b1, 1'b1);
    bus.joy_dig[1:0] = 2'b11;
    pulse_ce();
    check_pos("dig_both", 0, 8'h8C, 1'b1, 1'b0);
    bus.joy_dig[1:0] = 2'b01;
    pulse_ce();
    bus.joy_dig[1:0] = 2'b00;
    pulse_ce();
    check_pos("dig_left", 0, 8'h88, 1'b1, 1'b1);
  endtask

  task automatic test_mode_change();
    for (int i = 0; i < 2; i++) begin
      flip_spin(1, 8'd120);
      tick();
    end
    pulse_ce();
    check_pos("mc_f0", 1, 8'hF0, 1'b1, 1'b1);
    bus.cfg_mode[3:2] = 2'b11;
    bus.joy_dig[3:2]  = 2'b00;
    flip_spin(1, 8'd5);
    tick();
    pulse_ce();
    check_pos("mc_center1", 1, 8'h80, 1'b1, 1'b1);
    pulse_ce();
    check_pos("mc_center2", 1, 8'h80, 1'b1, 1'b0);
    bus.cfg_mode[3:2] = 2'b10;
    flip_spin(1, 8'd5);
    tick();
    pulse_ce();
    pulse_ce();
    check_pos("mc_spin_discard", 1, 8'h80, 1'b1, 1'b0);
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp_dz;
    flip_spin(1, 8'd5);
    pulse_ce();
    check_pos("sim_pre_event", 1, 8'h80, 1'b1, 1'b0);
    pulse_ce();
    check_pos("sim_post_event", 1, 8'h85, 1'b1, 1'b1);
`ifdef ANALOG_DEADZONE_EN
    exp_dz = 8'h80;
`else
    exp_dz = 8'h85;
`endif
    bus.cfg_mode[1:0]   = 2'b00;
    bus.joy_analog[7:0] = 8'h05;
    tick();
    pulse_ce();
    bus.joy_analog[7:0] = 8'h80;
    pulse_ce();
    checks++;
    if (bus.pos_out[7:0] !== exp_dz) begin
      failures++;
      $display("[TB] FAIL joy_deadzone: pos=%02h required %02h", bus.pos_out[7:0], exp_dz);
    end
    pulse_ce();
    check_pos("joy_min", 0, 8'h00, 1'b1, 1'b1);
    check_pos("independent", 1, 8'h85, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_joystick();
    test_paddle();
    test_spinner_saturation();
    test_digital();
    test_mode_change();
    test_simultaneous();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
